// File: rtl/prog_loader_pkg.sv
// Shared picoMIPS configuration: opcode set, instruction layout
// and the program-loader state encoding.
package cpuConfig;

   localparam int O_W = 6;
   localparam int R_W = 3;
   localparam int D_W = 8;

   typedef enum logic [O_W-1:0] {
      OP_NOP   = 6'h00,
      OP_ADD   = 6'h01,
      OP_ADDI  = 6'h02,
      OP_SUB   = 6'h03,
      OP_SUBI  = 6'h04,
      OP_MUL   = 6'h05,
      OP_MULI  = 6'h06,
      OP_LDI   = 6'h07,
      OP_MOV   = 6'h08,
      OP_BEQ   = 6'h09,
      OP_BNE   = 6'h0A,
      OP_WAIT0 = 6'h0B,
      OP_WAIT1 = 6'h0C,
      OP_JMP   = 6'h0D
   } opCode_t;

   typedef struct packed {
      opCode_t          op;
      logic [R_W-1:0]   rd;
      logic [R_W-1:0]   rs;
      logic [D_W-1:0]   imm;
   } instr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } loadState_t;

endpackage

// File: rtl/prog_loader_if.sv
// Instruction-stream input and program-memory write side of the
// loader, plus CPU hold and status flags.
interface prog_loader_if #(
   parameter int O_SIZE  = 6,
   parameter int R_SIZE  = 3,
   parameter int D_SIZE  = 8,
   parameter int PA_SIZE = 5
);

   localparam int W_SIZE = O_SIZE + 2*R_SIZE + D_SIZE;

   logic                loadStart;
   logic                inValid;
   logic                inReady;
   logic [O_SIZE-1:0]   inOp;
   logic [R_SIZE-1:0]   inRd;
   logic [R_SIZE-1:0]   inRs;
   logic [D_SIZE-1:0]   inImm;
   logic                inLast;
   logic                progWe;
   logic [PA_SIZE-1:0]  progAddr;
   logic [W_SIZE-1:0]   progData;
   logic                cpuHold;
   logic                done;
   logic                errIllegal;
   logic                errOverflow;
   logic [PA_SIZE:0]    loadedCount;

   modport master (
      output loadStart, inValid, inOp, inRd, inRs, inImm, inLast,
      input  inReady, progWe, progAddr, progData, cpuHold,
      input  done, errIllegal, errOverflow, loadedCount
   );

   modport slave (
      input  loadStart, inValid, inOp, inRd, inRs, inImm, inLast,
      output inReady, progWe, progAddr, progData, cpuHold,
      output done, errIllegal, errOverflow, loadedCount
   );

endinterface

// File: rtl/prog_loader_enc.sv
// Packs instruction fields MSB-first into {op, rd, rs, imm} and
// flags whether the opcode belongs to the legal opcode set.
module instr_encoder
   import cpuConfig::*;
#(
   parameter int O_SIZE = 6,
   parameter int R_SIZE = 3,
   parameter int D_SIZE = 8
) (
   input  logic [O_SIZE-1:0]               op_i,
   input  logic [R_SIZE-1:0]               rd_i,
   input  logic [R_SIZE-1:0]               rs_i,
   input  logic [D_SIZE-1:0]               imm_i,
   output logic [O_SIZE+2*R_SIZE+D_SIZE-1:0] word_o,
   output logic                            isLegal
);

   assign word_o = {op_i, rd_i, rs_i, imm_i};

   // Opcode legality: only enumerated opcodes may reach memory
   always_comb begin
      isLegal = 1'b0;
      unique case (op_i)
         O_SIZE'(OP_NOP),
         O_SIZE'(OP_ADD),
         O_SIZE'(OP_ADDI),
         O_SIZE'(OP_SUB),
         O_SIZE'(OP_SUBI),
         O_SIZE'(OP_MUL),
         O_SIZE'(OP_MULI),
         O_SIZE'(OP_LDI),
         O_SIZE'(OP_MOV),
         O_SIZE'(OP_BEQ),
         O_SIZE'(OP_BNE),
         O_SIZE'(OP_WAIT0),
         O_SIZE'(OP_WAIT1),
         O_SIZE'(OP_JMP): isLegal = 1'b1;
         default:         isLegal = 1'b0;
      endcase
   end

endmodule

// File: rtl/prog_loader.sv
// Program-memory writer: accepts instruction words, drops illegal
// ones, writes legal ones to sequential addresses, holds the CPU.
module prog_loader
   import cpuConfig::*;
#(
   parameter int O_SIZE  = 6,
   parameter int R_SIZE  = 3,
   parameter int D_SIZE  = 8,
   parameter int PA_SIZE = 5
) (
   input  logic       clk,
   input  logic       reset,
   prog_loader_if.slave bus
);

   localparam int W_SIZE = O_SIZE + 2*R_SIZE + D_SIZE;
   localparam logic [PA_SIZE:0] CNT_MAX = (PA_SIZE+1)'(2**PA_SIZE);

   loadState_t          state_q, state_d;
   logic [PA_SIZE-1:0]  wrAddr_q, wrAddr_d;
   logic [PA_SIZE:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [PA_SIZE-1:0]  addr_q, addr_d;
   logic [W_SIZE-1:0]   data_q, data_d;
   logic                hold_q, hold_d;
   logic                done_q, done_d;
   logic                errIll_q, errIll_d;
   logic                errOvf_q, errOvf_d;
   logic                fin_q, fin_d;
   logic                ovfPend_q, ovfPend_d;

   logic                inReady;
   logic                accept;
   logic                isLegal;
   logic [W_SIZE-1:0]   word;

   instr_encoder #(
      .O_SIZE (O_SIZE),
      .R_SIZE (R_SIZE),
      .D_SIZE (D_SIZE)
   ) u_enc (
      .op_i    (bus.inOp),
      .rd_i    (bus.inRd),
      .rs_i    (bus.inRs),
      .imm_i   (bus.inImm),
      .word_o  (word),
      .isLegal (isLegal)
   );

   assign inReady = (state_q == LOAD) && !bus.loadStart;
   assign accept  = bus.inValid && inReady;

   // Next state, write stage and status flags
   always_comb begin
      state_d   = state_q;
      wrAddr_d  = wrAddr_q;
      cnt_d     = cnt_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      hold_d    = hold_q;
      done_d    = done_q;
      errIll_d  = errIll_q;
      errOvf_d  = errOvf_q;
      fin_d     = 1'b0;
      ovfPend_d = 1'b0;

      // a write cycle just ended: count it
      if (we_q && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end

      // final word's write cycle just ended: release the CPU
      if (fin_q) begin
         hold_d = 1'b0;
         done_d = 1'b1;
      end

      // top-address write just ended without a last marker
      if (ovfPend_q) begin
         errOvf_d = 1'b1;
      end

      unique case (state_q)
         IDLE: ;
         LOAD: begin
            if (accept) begin
               if (isLegal) begin
                  we_d     = 1'b1;
                  addr_d   = wrAddr_q;
                  data_d   = word;
                  wrAddr_d = wrAddr_q + 1'b1;
                  if (!bus.inLast && (&wrAddr_q)) begin
                     state_d   = FULL;
                     ovfPend_d = 1'b1;
                  end
               end else begin
                  errIll_d = 1'b1;
               end
               if (bus.inLast) begin
                  state_d = IDLE;
                  fin_d   = 1'b1;
               end
            end
         end
         FULL: ;
         default: state_d = IDLE;
      endcase

      // restart wins over everything except an in-flight write
      if (bus.loadStart) begin
         state_d   = LOAD;
         wrAddr_d  = '0;
         cnt_d     = '0;
         hold_d    = 1'b1;
         done_d    = 1'b0;
         errIll_d  = 1'b0;
         errOvf_d  = 1'b0;
         fin_d     = 1'b0;
         ovfPend_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         wrAddr_q  <= '0;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         hold_q    <= 1'b0;
         done_q    <= 1'b0;
         errIll_q  <= 1'b0;
         errOvf_q  <= 1'b0;
         fin_q     <= 1'b0;
         ovfPend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wrAddr_q  <= wrAddr_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         hold_q    <= hold_d;
         done_q    <= done_d;
         errIll_q  <= errIll_d;
         errOvf_q  <= errOvf_d;
         fin_q     <= fin_d;
         ovfPend_q <= ovfPend_d;
      end
   end

   assign bus.inReady     = inReady;
   assign bus.progWe      = we_q;
   assign bus.progAddr    = addr_q;
   assign bus.progData    = data_q;
   assign bus.cpuHold     = hold_q;
   assign bus.done        = done_q;
   assign bus.errIllegal  = errIll_q;
   assign bus.errOverflow = errOvf_q;
   assign bus.loadedCount = cnt_q;

endmodule
